// File: rtl/prio_encoder_pipe.sv
// prio_encoder_pipe: one-hot / priority encoder with a single-entry registered output
// and a saturating error counter.
//
// Ports:
//   clk       - clock, all state changes on the rising edge
//   rst       - asynchronous active-high reset
//   din       - N-bit request vector
//   mode      - 0: strict one-hot encoding, 1: priority encoding (highest index wins)
//   in_valid  - din/mode valid this cycle
//   in_ready  - block can accept din this cycle
//   dout      - encoded index of the accepted input
//   err       - accepted input was invalid for its mode
//   out_valid - dout/err hold a result
//   out_ready - downstream consumes the result this cycle
//   clr_cnt   - synchronous clear of err_cnt (wins over an increment)
//   err_cnt   - saturating count of accepted transactions with err = 1
module prio_encoder_pipe #(
    parameter int unsigned N     = 8,
    parameter int unsigned CNT_W = 8,
    localparam int unsigned W    = (N > 2) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     din,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [W-1:0]     dout,
    output logic             err,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [N-1:0]     One    = {{(N-1){1'b0}}, 1'b1};

    logic [W-1:0] pri_idx;
    logic         any_set;
    logic         one_hot;
    logic [W-1:0] enc_dout;
    logic         enc_err;
    logic         accept;

    // Highest set index; for a one-hot vector this is also the only set index.
    always_comb begin
        pri_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (din[i]) begin
                pri_idx = W'(i);
            end
        end
    end

    always_comb begin
        any_set = |din;
        // Clearing the lowest set bit leaves zero only if exactly one bit was set.
        one_hot = any_set && ((din & (din - One)) == '0);
        if (mode) begin
            enc_dout = any_set ? pri_idx : '0;
            enc_err  = !any_set;
        end else begin
            enc_dout = one_hot ? pri_idx : '0;
            enc_err  = !one_hot;
        end
    end

    // A full register may drain and refill on the same edge.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            dout      <= '0;
            err       <= 1'b0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                dout      <= enc_dout;
                err       <= enc_err;
            end else if (out_valid && out_ready) begin
                // Consumed with nothing new: keep dout/err, just drop valid.
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (clr_cnt) begin
            err_cnt <= '0;
        end else if (accept && enc_err && (err_cnt != CntMax)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_prio_encoder_pipe.sv
module tb_prio_encoder_pipe;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance a: N=8, CNT_W=8
    logic [7:0] a_din = '0;
    logic       a_mode = 1'b0, a_iv = 1'b0, a_or = 1'b0, a_clr = 1'b0;
    logic       a_ir, a_err, a_ov;
    logic [2:0] a_dout;
    logic [7:0] a_cnt;

    // Instance c: N=8, CNT_W=2 (saturation)
    logic [7:0] c_din = '0;
    logic       c_mode = 1'b0, c_iv = 1'b0, c_or = 1'b0, c_clr = 1'b0;
    logic       c_ir, c_err, c_ov;
    logic [2:0] c_dout;
    logic [1:0] c_cnt;

    // Instance w: N=64
    logic [63:0] w_din = '0;
    logic        w_mode = 1'b0, w_iv = 1'b0, w_or = 1'b0, w_clr = 1'b0;
    logic        w_ir, w_err, w_ov;
    logic [5:0]  w_dout;
    logic [7:0]  w_cnt;

    prio_encoder_pipe #(.N(8), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .din(a_din), .mode(a_mode), .in_valid(a_iv),
        .in_ready(a_ir), .dout(a_dout), .err(a_err), .out_valid(a_ov),
        .out_ready(a_or), .clr_cnt(a_clr), .err_cnt(a_cnt)
    );

    prio_encoder_pipe #(.N(8), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .din(c_din), .mode(c_mode), .in_valid(c_iv),
        .in_ready(c_ir), .dout(c_dout), .err(c_err), .out_valid(c_ov),
        .out_ready(c_or), .clr_cnt(c_clr), .err_cnt(c_cnt)
    );

    prio_encoder_pipe #(.N(64), .CNT_W(8)) dut_w (
        .clk(clk), .rst(rst), .din(w_din), .mode(w_mode), .in_valid(w_iv),
        .in_ready(w_ir), .dout(w_dout), .err(w_err), .out_valid(w_ov),
        .out_ready(w_or), .clr_cnt(w_clr), .err_cnt(w_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input int ov, input int d, input int e, input int c);
        chk({tag, ".out_valid"}, a_ov, 64'(ov));
        chk({tag, ".dout"}, a_dout, 64'(d));
        chk({tag, ".err"}, a_err, 64'(e));
        chk({tag, ".err_cnt"}, a_cnt, 64'(c));
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #2;
        chk_a("reset", 0, 0, 0, 0);
        chk("reset.in_ready", a_ir, 1);
        chk("reset.c_cnt", c_cnt, 0);
        chk("reset.w_ov", w_ov, 0);
        @(posedge clk);
        #1 chk("reset_edge.out_valid", a_ov, 0);
        @(negedge clk);
        rst = 1'b0;

        // Strict one-hot
        a_mode = 1'b0; a_din = 8'b0010_0000; a_iv = 1'b1; a_or = 1'b1;
        tick();
        chk_a("strict_onehot", 1, 5, 0, 0);

        // Priority with multiple bits, then strict on the same vector
        a_mode = 1'b1; a_din = 8'b0100_1010;
        tick();
        chk_a("prio_multi", 1, 6, 0, 0);
        a_mode = 1'b0;
        tick();
        chk_a("strict_multi", 1, 0, 1, 1);

        // Load a result, then hold it for three cycles
        a_mode = 1'b1; a_din = 8'b1000_0000;
        tick();
        chk_a("prio_top", 1, 7, 0, 1);
        a_or = 1'b0; a_mode = 1'b0; a_din = 8'b0000_0001;
        #1 chk("hold.in_ready_comb", a_ir, 0);
        for (int i = 0; i < 3; i++) begin
            a_din = 8'(1 << i);
            tick();
            chk_a("hold", 1, 7, 0, 1);
            chk("hold.in_ready", a_ir, 0);
        end

        // Drain and refill on the same edge
        a_or = 1'b1; a_mode = 1'b0; a_din = 8'b0000_1000;
        #1 chk("refill.in_ready", a_ir, 1);
        tick();
        chk_a("refill", 1, 3, 0, 1);

        // Consume with nothing new: valid drops, data kept
        a_iv = 1'b0;
        tick();
        chk_a("consume", 0, 3, 0, 1);

        // Idle with changing din: no effect
        a_din = 8'b0000_0000; a_mode = 1'b1;
        tick();
        chk_a("idle", 0, 3, 0, 1);

        // Priority with zero input
        a_iv = 1'b1;
        tick();
        chk_a("prio_zero", 1, 0, 1, 2);

        // Clear without a transfer
        a_iv = 1'b0; a_clr = 1'b1;
        tick();
        chk_a("clr", 0, 0, 1, 0);
        a_clr = 1'b0;

        // Saturation with CNT_W=2
        c_mode = 1'b0; c_din = 8'h00; c_iv = 1'b1; c_or = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("sat.err", c_err, 1);
            chk("sat.err_cnt", c_cnt, (i < 3) ? 64'(i + 1) : 64'd3);
        end
        // Clear coinciding with an erroring transfer: clear wins
        c_clr = 1'b1;
        tick();
        chk("clr_wins.err_cnt", c_cnt, 0);
        chk("clr_wins.err", c_err, 1);
        chk("clr_wins.out_valid", c_ov, 1);
        c_clr = 1'b0; c_iv = 1'b0;

        // Asynchronous reset while a result is held
        a_iv = 1'b1; a_or = 1'b1; a_mode = 1'b0; a_din = 8'b0000_0011;
        tick();
        chk_a("pre_rst_err", 1, 0, 1, 1);
        a_mode = 1'b1; a_din = 8'b0100_0000;
        tick();
        chk_a("pre_rst_load", 1, 6, 0, 1);
        a_iv = 1'b0; a_or = 1'b0;
        tick();
        chk_a("pre_rst_hold", 1, 6, 0, 1);
        #2 rst = 1'b1;
        #1;
        chk_a("async_rst", 0, 0, 0, 0);
        chk("async_rst.in_ready", a_ir, 1);
        @(negedge clk);
        rst = 1'b0;
        a_iv = 1'b1; a_or = 1'b1; a_mode = 1'b1; a_din = 8'b0001_0000;
        #1 chk("post_rst.out_valid_before", a_ov, 0);
        tick();
        chk_a("post_rst", 1, 4, 0, 0);
        a_iv = 1'b0;

        // N=64 boundaries
        w_mode = 1'b1; w_iv = 1'b1; w_or = 1'b1;
        w_din = 64'h8000_0000_0000_0000;
        tick();
        chk("w63.dout", w_dout, 63);
        chk("w63.err", w_err, 0);
        chk("w63.out_valid", w_ov, 1);
        w_din = 64'h0000_0000_0000_0001;
        tick();
        chk("w0.dout", w_dout, 0);
        chk("w0.err", w_err, 0);
        w_mode = 1'b0; w_din = 64'h8000_0000_0000_0000;
        tick();
        chk("w63_strict.dout", w_dout, 63);
        chk("w63_strict.err", w_err, 0);
        w_din = 64'h8000_0000_0000_0001;
        tick();
        chk("w_strict_multi.dout", w_dout, 0);
        chk("w_strict_multi.err", w_err, 1);
        chk("w_strict_multi.err_cnt", w_cnt, 1);
        w_iv = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prio_encoder_pipe.md
PRIO_ENCODER_PIPE -- requirements
Module: prio_encoder_pipe

Interface
REQ-001 Parameter N, default 8: number of request inputs; legal range 2..64.
REQ-002 Parameter CNT_W, default 8: width of the error counter; legal range 1..16.
REQ-003 Derived width W = clog2(N), minimum 1; this is the width of dout.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 din  input  N  request vector; bit i set means input i is active.
REQ-007 mode  input  1  0 = strict one-hot encoding, 1 = priority encoding (highest index wins).
REQ-008 in_valid  input  1  din/mode are valid this cycle.
REQ-009 in_ready  output  1  block can accept din this cycle.
REQ-010 dout  output  W  encoded index of the accepted input.
REQ-011 err  output  1  the accepted input was invalid for its mode.
REQ-012 out_valid  output  1  dout/err hold a result.
REQ-013 out_ready  input  1  downstream consumes the result this cycle.
REQ-014 clr_cnt  input  1  synchronous clear of err_cnt.
REQ-015 err_cnt  output  CNT_W  saturating count of accepted transactions with err = 1.

Function
REQ-016 Encoding shall be computed combinationally from din/mode and captured into a one-entry output register; there is no other storage.
REQ-017 Acceptance: a transfer occurs at a rising edge where in_valid = 1 and in_ready = 1; mode is sampled at that same edge.
REQ-018 in_ready = !out_valid || out_ready (combinational; a full register drains and refills in the same cycle).
REQ-019 Latency: a result is visible on dout/err with out_valid = 1 exactly one cycle after its acceptance edge.
REQ-020 Strict mode, popcount(din) = 1: dout = index of the set bit, err = 0.
REQ-021 Strict mode, popcount(din) != 1 (zero or multiple bits): dout = 0, err = 1.
REQ-022 Priority mode, din != 0: dout = highest set index, err = 0.
REQ-023 Priority mode, din = 0: dout = 0, err = 1.
REQ-024 Out handshake: the result is consumed at an edge where out_valid = 1 and out_ready = 1.
REQ-025 Hold: while out_valid = 1 and out_ready = 0, dout and err shall remain stable and in_ready shall be 0.
REQ-026 Drain and refill: consume plus accept at the same edge shall keep out_valid = 1 and load the new result.
REQ-027 Consume with no accept: out_valid shall go to 0; dout and err keep their last value.
REQ-028 in_valid = 0 with an empty register: no state change other than err_cnt clearing.
REQ-029 err_cnt shall increment by 1 at each acceptance edge whose computed err = 1.
REQ-030 err_cnt shall saturate at 2^CNT_W - 1 and never wrap.
REQ-031 clr_cnt = 1 shall set err_cnt to 0 at the next edge; if an increment falls on the same edge, the clear wins.
REQ-032 Inputs are ignored unless in_valid = 1; din/mode changes while not accepted have no effect.

Reset
REQ-033 On rst = 1, asynchronously and without waiting for clk: out_valid = 0, dout = 0, err = 0, err_cnt = 0.
REQ-034 While rst = 1, in_ready = 1 (follows REQ-018); no transfer is accepted and any held result is discarded.
REQ-035 Normal operation starts at the first rising edge after rst deasserts.

Verification
REQ-036 N=8, mode=0, din=8'b0010_0000 accepted, out_ready=1 -> next cycle dout=5, err=0, out_valid=1, err_cnt unchanged.
REQ-037 N=8, mode=1, din=8'b0100_1010 -> dout=6, err=0; then mode=0 with the same din -> dout=0, err=1, err_cnt += 1.
REQ-038 out_ready=0 for 3 cycles with a result held -> in_ready=0, dout/err stable, new din ignored; with out_ready=1 and in_valid=1 together -> out_valid stays 1 with the new result the next cycle.
REQ-039 CNT_W=2, five strict-mode transfers with din=0 -> err_cnt reads 1,2,3,3,3; clr_cnt asserted on the edge of an erroring transfer -> err_cnt=0.
REQ-040 rst asserted mid-hold, between clock edges -> out_valid, dout, err and err_cnt go to 0 immediately; the first accepted transfer after release appears one cycle later.
REQ-041 N=64, mode=1, din with only bit 63 set and then only bit 0 set -> dout=63 then dout=0, err=0 for both.
